// File: rtl/alu_serial_divider.sv
// Restoring serial divider: one quotient bit per clock, start/done handshake.
// Optional sign-magnitude sign handling enabled by `define ALU_DIVIDER_SIGN_EN.
module alu_serial_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_DIVIDER_SIGN_EN
  input  logic             a_sign,
  input  logic             b_sign,
  output logic             q_sign,
  output logic             r_sign,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   step;
`ifdef ALU_DIVIDER_SIGN_EN
  logic             as_q, as_d, bs_q, bs_d, qs_q, qs_d, rs_q, rs_d;
`endif

  // The partial remainder always stays below the divisor, so only its low
  // WIDTH bits are stored; the extra bit exists only in the trial subtraction.
  function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] p,
                                              input logic             msb,
                                              input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] ps, t;
    ps = {p, msb};
    t  = ps - {1'b0, dvs};
    if (t[WIDTH]) return {ps[WIDTH-1:0], 1'b0};
    else          return {t[WIDTH-1:0], 1'b1};
  endfunction

  assign step = div_step(p_q, dvd_q[WIDTH-1], dvs_q);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef ALU_DIVIDER_SIGN_EN
    as_d = as_q;
    bs_d = bs_q;
    qs_d = qs_q;
    rs_d = rs_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (b != '0) begin
            state_d = RUN;
            dvd_d   = a;
            dvs_d   = b;
            p_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
`ifdef ALU_DIVIDER_SIGN_EN
            as_d = a_sign;
            bs_d = b_sign;
`endif
          end else begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = a;
            dz_d    = 1'b1;
`ifdef ALU_DIVIDER_SIGN_EN
            qs_d = 1'b0;
            rs_d = (a != '0) && a_sign;
`endif
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], step[0]};
        p_d   = step[WIDTH:1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = {dvd_q[WIDTH-2:0], step[0]};
          rem_d   = step[WIDTH:1];
          dz_d    = 1'b0;
`ifdef ALU_DIVIDER_SIGN_EN
          qs_d = ({dvd_q[WIDTH-2:0], step[0]} != '0) && (as_q ^ bs_q);
          rs_d = (step[WIDTH:1] != '0) && as_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef ALU_DIVIDER_SIGN_EN
      as_q <= 1'b0;
      bs_q <= 1'b0;
      qs_q <= 1'b0;
      rs_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef ALU_DIVIDER_SIGN_EN
      as_q <= as_d;
      bs_q <= bs_d;
      qs_q <= qs_d;
      rs_q <= rs_d;
`endif
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign q     = quo_q;
  assign r     = rem_q;
  assign dz    = dz_q;
`ifdef ALU_DIVIDER_SIGN_EN
  assign q_sign = qs_q;
  assign r_sign = rs_q;
`endif

endmodule
